// File: rtl/td4_pkg.sv
// Shared TD4 definitions: datapath width and the destination encoding used by
// both the read-side selector and the write-side register bank.
package td4_pkg;

  localparam int unsigned WIDTH = 4;

  typedef enum logic [1:0] {
    DST_A   = 2'b00,
    DST_B   = 2'b01,
    DST_OUT = 2'b10,
    DST_PC  = 2'b11
  } dst_e;

endpackage : td4_pkg

// File: rtl/load_decoder.sv
// One-hot destination decode for the ALU write-back.
// The PC strobe is qualified by the JNC/carry condition.
module load_decoder
  import td4_pkg::*;
(
  input  logic [1:0] ld_sel,
  input  logic       ld_en,
  input  logic       jnc,
  input  logic       carry,
  output logic       ld_a_c,
  output logic       ld_b_c,
  output logic       ld_out_c,
  output logic       ld_pc_c
);

  // With ld_en low every strobe stays low, whatever ld_sel holds.
  always_comb begin
    ld_a_c   = 1'b0;
    ld_b_c   = 1'b0;
    ld_out_c = 1'b0;
    ld_pc_c  = 1'b0;
    if (ld_en) begin
      case (ld_sel)
        DST_A:   ld_a_c   = 1'b1;
        DST_B:   ld_b_c   = 1'b1;
        DST_OUT: ld_out_c = 1'b1;
        DST_PC:  ld_pc_c  = ~jnc | ~carry;
        default: ld_pc_c  = 1'b0;
      endcase
    end
  end

endmodule : load_decoder

// File: rtl/register_bank.sv
// TD4 architectural state: A, B, OUT, PC and the carry flag.
// State advances only on cycles with step=1.
module register_bank #(
  parameter int unsigned               WIDTH    = td4_pkg::WIDTH,
  parameter logic [WIDTH-1:0]          PC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [1:0]       ld_sel,
  input  logic             ld_en,
  input  logic             jnc,
  input  logic [WIDTH-1:0] d,
  input  logic             c_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] pc,
  output logic             carry,
  output logic             jump_taken
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             carry_q, carry_d;
  logic             jump_taken_q, jump_taken_d;

  logic ld_a_c, ld_b_c, ld_out_c, ld_pc_c;

  load_decoder u_load_decoder (
    .ld_sel   (ld_sel),
    .ld_en    (ld_en),
    .jnc      (jnc),
    .carry    (carry_q),
    .ld_a_c   (ld_a_c),
    .ld_b_c   (ld_b_c),
    .ld_out_c (ld_out_c),
    .ld_pc_c  (ld_pc_c)
  );

  // Next-state: hold by default; a step writes one destination and moves PC.
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    out_d        = out_q;
    pc_d         = pc_q;
    carry_d      = carry_q;
    jump_taken_d = 1'b0;
    if (step) begin
      if (ld_a_c)   a_d   = d;
      if (ld_b_c)   b_d   = d;
      if (ld_out_c) out_d = d;
      pc_d         = ld_pc_c ? d : pc_q + WIDTH'(1);
      carry_d      = c_in;
      jump_taken_d = ld_pc_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      out_q        <= '0;
      pc_q         <= PC_RESET;
      carry_q      <= 1'b0;
      jump_taken_q <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      out_q        <= out_d;
      pc_q         <= pc_d;
      carry_q      <= carry_d;
      jump_taken_q <= jump_taken_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign out_port   = out_q;
  assign pc         = pc_q;
  assign carry      = carry_q;
  assign jump_taken = jump_taken_q;

endmodule : register_bank

// File: tb/tb_register_bank.sv
// Directed test of register_bank with hand-computed expected register values.
module tb_register_bank;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         step;
  logic [1:0]   ld_sel;
  logic         ld_en;
  logic         jnc;
  logic [W-1:0] d;
  logic         c_in;
  logic [W-1:0] a, b, out_port, pc;
  logic         carry, jump_taken;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  register_bank #(.WIDTH(W), .PC_RESET(4'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .ld_sel     (ld_sel),
    .ld_en      (ld_en),
    .jnc        (jnc),
    .d          (d),
    .c_in       (c_in),
    .a          (a),
    .b          (b),
    .out_port   (out_port),
    .pc         (pc),
    .carry      (carry),
    .jump_taken (jump_taken)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cycle(input logic s, input logic [1:0] sel, input logic en,
                       input logic j, input logic [W-1:0] dv, input logic ci);
    @(negedge clk);
    step = s; ld_sel = sel; ld_en = en; jnc = j; d = dv; c_in = ci;
    @(posedge clk);
    #1;
    step = 1'b0; ld_en = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                            input logic [W-1:0] eo, input logic [W-1:0] ep,
                            input logic ec, input logic ej);
    check({tag, ".a"},   8'(a), 8'(ea));
    check({tag, ".b"},   8'(b), 8'(eb));
    check({tag, ".out"}, 8'(out_port), 8'(eo));
    check({tag, ".pc"},  8'(pc), 8'(ep));
    check({tag, ".c"},   8'(carry), 8'(ec));
    check({tag, ".jt"},  8'(jump_taken), 8'(ej));
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; ld_sel = 2'b00; ld_en = 1'b0; jnc = 1'b0; d = '0; c_in = 1'b0;
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0);
    check_regs("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Three plain steps: PC counts, nothing else moves.
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b00, 1'b0, 1'b0, 4'hF, 1'b0);
    check_regs("inc3", 4'h0, 4'h0, 4'h0, 4'h3, 1'b0, 1'b0);

    cycle(1'b1, 2'b00, 1'b1, 1'b0, 4'h5, 1'b0);
    check_regs("ld_a", 4'h5, 4'h0, 4'h0, 4'h4, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 1'b1, 1'b0, 4'hA, 1'b0);
    check_regs("ld_b", 4'h5, 4'hA, 4'h0, 4'h5, 1'b0, 1'b0);

    // Unconditional jump to 15, idle cycle clears jump_taken, then wrap.
    cycle(1'b1, 2'b11, 1'b1, 1'b0, 4'hF, 1'b0);
    check_regs("jmp_f", 4'h5, 4'hA, 4'h0, 4'hF, 1'b0, 1'b1);
    cycle(1'b0, 2'b11, 1'b1, 1'b0, 4'h3, 1'b1);
    check_regs("idle1", 4'h5, 4'hA, 4'h0, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 1'b0, 1'b0, 4'h7, 1'b0);
    check_regs("wrap", 4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 4'h7, 1'b0);
    check_regs("idle2", 4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0);

    // JNC with carry=0 taken; carry picks up c_in=1 on the same edge.
    cycle(1'b1, 2'b11, 1'b1, 1'b1, 4'h6, 1'b1);
    check_regs("jnc_c0", 4'h5, 4'hA, 4'h0, 4'h6, 1'b1, 1'b1);
    cycle(1'b1, 2'b11, 1'b1, 1'b1, 4'h6, 1'b1);
    check_regs("jnc_c1", 4'h5, 4'hA, 4'h0, 4'h7, 1'b1, 1'b0);
    cycle(1'b1, 2'b11, 1'b1, 1'b0, 4'h6, 1'b0);
    check_regs("jmp_c1", 4'h5, 4'hA, 4'h0, 4'h6, 1'b0, 1'b1);

    cycle(1'b1, 2'b10, 1'b1, 1'b0, 4'h9, 1'b1);
    check_regs("ld_out", 4'h5, 4'hA, 4'h9, 4'h7, 1'b1, 1'b0);
    cycle(1'b1, 2'b00, 1'b0, 1'b0, 4'h2, 1'b0);
    check_regs("carry0", 4'h5, 4'hA, 4'h9, 4'h8, 1'b0, 1'b0);

    // ld_en low with an arbitrary select writes nothing.
    cycle(1'b1, 2'bxx, 1'b0, 1'b1, 4'h1, 1'b0);
    check_regs("sel_x", 4'h5, 4'hA, 4'h9, 4'h9, 1'b0, 1'b0);

    // Reset colliding with a write step wins the edge.
    @(negedge clk); rst = 1'b1;
    cycle(1'b1, 2'b00, 1'b1, 1'b0, 4'hF, 1'b1);
    check_regs("rst_step", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_bank
